// File: rtl/sha3_pkg.sv
// sha3_pkg
// Shared definitions for the SHA-3 front end: fixed data widths of the
// low-throughput core interface and the state encoding of the byte packer.
package sha3_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int BYTE_NUM_W = 2;

  // Packer progress through one message.
  typedef enum logic [1:0] {
    RUN  = 2'd0,  // accepting bytes
    TERM = 2'd1,  // message ended on a word boundary, empty terminator owed
    DONE = 2'd2   // terminator issued, wait for reset
  } state_e;

endpackage

// File: rtl/sha3_byte_packer.sv
// sha3_byte_packer
// Packs a valid/ready byte stream big-endian (first byte in bits 31:24) into
// 32-bit words for the SHA-3 core, emits the final partial word or the empty
// terminator word, and stalls the byte source while the core buffer is full.
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready - byte source handshake
//   k_in, k_in_ready, k_is_last, k_byte_num - word slot driving the core
//   k_buffer_full   - core back-pressure
//   done            - terminator delivered; sticky until reset
module sha3_byte_packer
  import sha3_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BYTE_W-1:0]     s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [WORD_W-1:0]     k_in,
  output logic                  k_in_ready,
  output logic                  k_is_last,
  output logic [BYTE_NUM_W-1:0] k_byte_num,
  input  logic                  k_buffer_full,
  output logic                  done
);

  state_e                  state_q, state_d;
  logic [23:0]             asm_q, asm_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [WORD_W-1:0]       k_in_q, k_in_d;
  logic                    k_in_ready_q, k_in_ready_d;
  logic                    k_is_last_q, k_is_last_d;
  logic [BYTE_NUM_W-1:0]   k_byte_num_q, k_byte_num_d;
  logic                    done_q, done_d;

  logic                    slot_free;
  logic                    s_ready_c;
  logic [WORD_W-1:0]       part_word;

  // Next-state, slot and handshake logic.
  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    cnt_d        = cnt_q;
    k_in_d       = k_in_q;
    k_in_ready_d = k_in_ready_q;
    k_is_last_d  = k_is_last_q;
    k_byte_num_d = k_byte_num_q;
    s_ready_c    = 1'b0;
    part_word    = 32'd0;

    slot_free = ~k_in_ready_q | ~k_buffer_full;

    // A transfer empties the slot; a load below in the same cycle overrides
    // this, giving back-to-back words with no bubble.
    if (k_in_ready_q && !k_buffer_full) begin
      k_in_d       = 32'd0;
      k_in_ready_d = 1'b0;
      k_is_last_d  = 1'b0;
      k_byte_num_d = 2'd0;
    end

    // Final partial word: held bytes plus the new one, left-aligned.
    case (cnt_q)
      2'd0:    part_word = {s_data, 24'd0};
      2'd1:    part_word = {asm_q[7:0], s_data, 16'd0};
      default: part_word = {asm_q[15:0], s_data, 8'd0};
    endcase

    case (state_q)
      RUN: begin
        s_ready_c = slot_free;
        if (s_valid && slot_free) begin
          if (cnt_q == 2'd3) begin
            k_in_d       = {asm_q, s_data};
            k_in_ready_d = 1'b1;
            k_is_last_d  = 1'b0;
            k_byte_num_d = 2'd0;
            asm_d        = 24'd0;
            cnt_d        = 2'd0;
            // Message ended exactly on a word boundary.
            if (s_last) begin
              state_d = TERM;
            end else begin
              state_d = RUN;
            end
          end else if (s_last) begin
            k_in_d       = part_word;
            k_in_ready_d = 1'b1;
            k_is_last_d  = 1'b1;
            k_byte_num_d = cnt_q + 2'd1;
            asm_d        = 24'd0;
            cnt_d        = 2'd0;
            state_d      = DONE;
          end else begin
            asm_d = {asm_q[15:0], s_data};
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      TERM: begin
        if (slot_free) begin
          k_in_d       = 32'd0;
          k_in_ready_d = 1'b1;
          k_is_last_d  = 1'b1;
          k_byte_num_d = 2'd0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    done_d = (state_d == DONE) && !k_in_ready_d;
  end

  // State and slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      asm_q        <= 24'd0;
      cnt_q        <= 2'd0;
      k_in_q       <= 32'd0;
      k_in_ready_q <= 1'b0;
      k_is_last_q  <= 1'b0;
      k_byte_num_q <= 2'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      cnt_q        <= cnt_d;
      k_in_q       <= k_in_d;
      k_in_ready_q <= k_in_ready_d;
      k_is_last_q  <= k_is_last_d;
      k_byte_num_q <= k_byte_num_d;
      done_q       <= done_d;
    end
  end

  // s_ready is forced low during the reset cycle itself.
  assign s_ready    = s_ready_c & ~reset;
  assign k_in       = k_in_q;
  assign k_in_ready = k_in_ready_q;
  assign k_is_last  = k_is_last_q;
  assign k_byte_num = k_byte_num_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sha3_byte_packer.sv
module tb_sha3_byte_packer;
  import sha3_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] k_in;
  logic        k_in_ready;
  logic        k_is_last;
  logic [1:0]  k_byte_num;
  logic        k_buffer_full;
  logic        done;

  sha3_byte_packer dut (
    .clk           (clk),
    .reset         (reset),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .k_in          (k_in),
    .k_in_ready    (k_in_ready),
    .k_is_last     (k_is_last),
    .k_byte_num    (k_byte_num),
    .k_buffer_full (k_buffer_full),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic        last;
    logic [1:0]  num;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] msg[$];
  int         n_vec = 0;
  int         n_mis = 0;
  logic       mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every slot transfer against the oldest expected word.
  always @(negedge clk) begin
    if (mon_en && k_in_ready && !k_buffer_full) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {31'd0, k_in_ready}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word", k_in, e.word);
        check("is_last", {31'd0, k_is_last}, {31'd0, e.last});
        check("byte_num", {30'd0, k_byte_num}, {30'd0, e.num});
      end
    end
  end

  // Reference packing of msg[] into the expected word sequence.
  task automatic push_expect();
    int   n;
    int   i;
    exp_t e;
    n = msg.size();
    i = 0;
    while (n - i >= 4) begin
      e.word = {msg[i], msg[i+1], msg[i+2], msg[i+3]};
      e.last = 1'b0;
      e.num  = 2'd0;
      sb.push_back(e);
      i += 4;
    end
    e.word = 32'd0;
    e.last = 1'b1;
    e.num  = 2'(n - i);
    for (int k = 0; k < n - i; k++) e.word[31-8*k -: 8] = msg[i+k];
    sb.push_back(e);
  endtask

  // Offer one byte until accepted; returns the number of cycles spent.
  task automatic send_byte(input logic [7:0] b, input logic last, output int cyc);
    logic ok;
    s_data  = b;
    s_last  = last;
    s_valid = 1'b1;
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 50) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_msg();
    int c;
    int total;
    total = 0;
    push_expect();
    for (int i = 0; i < msg.size(); i++) begin
      send_byte(msg[i], (i == msg.size() - 1), c);
      total += c;
    end
    check("throughput_cycles", total, msg.size());
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done", {31'd0, done}, 32'd1);
    check("done_s_ready", {31'd0, s_ready}, 32'd0);
    check("done_k_in_ready", {31'd0, k_in_ready}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_k_in", k_in, 32'd0);
    check("rst_k_in_ready", {31'd0, k_in_ready}, 32'd0);
    check("rst_k_is_last", {31'd0, k_is_last}, 32'd0);
    check("rst_k_byte_num", {30'd0, k_byte_num}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("run_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    reset = 1'b1; s_data = 8'd0; s_valid = 1'b0; s_last = 1'b0; k_buffer_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 4n message: full word then empty terminator.
    do_reset();
    msg = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_msg();
    wait_done();

    // 5 bytes: full word then 1-byte partial.
    do_reset();
    msg = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_msg();
    wait_done();

    // 3 bytes: single partial word, latency of one cycle.
    do_reset();
    msg = '{8'h01, 8'h02, 8'h03};
    push_expect();
    send_byte(8'h01, 1'b0, c);
    send_byte(8'h02, 1'b0, c);
    send_byte(8'h03, 1'b1, c);
    check("latency_k_in_ready", {31'd0, k_in_ready}, 32'd1);
    wait_done();

    // Back-pressure with a word pending.
    do_reset();
    msg = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    push_expect();
    for (int i = 0; i < 4; i++) send_byte(msg[i], 1'b0, c);
    k_buffer_full = 1'b1;
    s_data  = 8'h14;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_k_in", k_in, 32'h10111213);
      check("stall_k_in_ready", {31'd0, k_in_ready}, 32'd1);
      check("stall_s_ready", {31'd0, s_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    k_buffer_full = 1'b0;
    for (int i = 4; i < 8; i++) send_byte(msg[i], (i == 7), c);
    wait_done();

    // Reset mid-message, then a clean 4-byte message.
    do_reset();
    send_byte(8'h55, 1'b0, c);
    send_byte(8'h66, 1'b0, c);
    do_reset();
    msg = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_msg();
    wait_done();

    // DONE ignores further input.
    s_valid = 1'b1;
    s_data  = 8'h99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("done_hold_s_ready", {31'd0, s_ready}, 32'd0);
      check("done_hold_k_in_ready", {31'd0, k_in_ready}, 32'd0);
    end
    s_valid = 1'b0;
    check("done_hold_sb", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sha3_byte_packer.md
# sha3_byte_packer

Upstream feeder for the low-throughput SHA-3 core. It turns a byte stream with a valid/ready handshake into the 32-bit word interface the core expects: `in`, `in_ready`, `is_last`, `byte_num` in, `buffer_full` back. It packs bytes big-endian, with the first byte in bits 31:24. It generates the final partial word or empty terminator word, and stalls the byte source while the core's buffer is full. One instance sits between the message source and the hash core.

## Interface
- Parameters: none; widths are fixed by the core (8-bit bytes, 32-bit words).
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high; clears all state.
- `s_data` input 8: message byte.
- `s_valid` input 1: `s_data` is valid.
- `s_last` input 1: this byte is the final byte of the message; qualified by `s_valid`.
- `s_ready` output 1: byte accepted when `s_valid & s_ready`.
- `k_in` output 32: word to core `in`.
- `k_in_ready` output 1: to core `in_ready`; word slot occupied.
- `k_is_last` output 1: to core `is_last`; 0 whenever `k_in_ready` = 0.
- `k_byte_num` output 2: to core `byte_num`; meaningful only when `k_is_last` = 1.
- `k_buffer_full` input 1: from core `buffer_full`.
- `done` output 1: terminator word delivered; no further input accepted until reset.

## Operation
- Registers:
  - `asm[23:0]` holds the partial word.
  - `cnt[1:0]` counts bytes held, 0..3.
  - The one-word output slot holds `k_in`, `k_in_ready`, `k_is_last` and `k_byte_num`.
  - An FSM holds the state.
- Slot transfer: `k_in_ready & ~k_buffer_full`. The slot clears that cycle unless it is reloaded. While `k_buffer_full` = 1, all slot outputs hold stable.
- `slot_free` = `~k_in_ready | ~k_buffer_full`.
- FSM states:
  - **RUN**:
    - `s_ready` = `slot_free`. It never depends on `s_valid` or `s_last`.
    - Accepted byte, `cnt` < 3, `s_last` = 0: shift the byte into `asm` and increment `cnt`.
    - Accepted byte, `cnt` = 3: load the slot with `{asm, byte}`, `is_last` = 0; `cnt` goes to 0.
      - If `s_last` = 1, go to **TERM**.
    - Accepted byte, `cnt` < 3, `s_last` = 1: load the slot with the bytes left-aligned and the unused low bytes zero, `is_last` = 1, `byte_num` = `cnt`+1 (1..3). Go to **DONE**.
  - **TERM**:
    - `s_ready` = 0.
    - When `slot_free`, load the slot with `k_in` = 0, `is_last` = 1, `byte_num` = 0. Go to **DONE**.
  - **DONE**:
    - `s_ready` = 0.
    - `done` = 1 once the slot is empty.
    - The state is held until `reset`, because the core's state is sticky until reset.
- Zero-length messages are not representable on the byte interface and are unsupported.
- `s_valid` with `s_ready` = 0 is a source stall; no byte is lost or duplicated.

## Timing
- Reset values:
  - `s_ready` = 0 in the reset cycle, then 1 in RUN with an empty slot.
  - `k_in` = 0, `k_in_ready` = 0, `k_is_last` = 0, `k_byte_num` = 0, `done` = 0.
  - FSM = RUN, `cnt` = 0.
- Latency: the byte completing a word, or the last byte, is accepted at cycle t; `k_in_ready` = 1 at t+1.
- Throughput: one byte per cycle while the core is not full, i.e. one word per 4 cycles.
- Simultaneous drain and reload: when the slot transfers in the same cycle a new word is loaded, the new word appears next cycle with no bubble.
- A message of length 4n always emits the empty terminator word one transfer after the final full word.
- `reset` mid-message discards `asm` and the slot contents; the next cycle is a clean RUN.

## Structure
- Shared package `sha3_pkg` holds:
  - the FSM state enum (RUN, TERM, DONE);
  - `BYTE_W` = 8, `WORD_W` = 32, `BYTE_NUM_W` = 2.
- Single module, no sub-module. The slot is a few flops, and splitting it out adds only port noise.

## Test plan
- 4 bytes 0x11,0x22,0x33,0x44 with `s_last` on the 4th, `k_buffer_full` = 0:
  - word 0x11223344, `k_is_last` = 0;
  - next transfer: word 0x00000000, `k_is_last` = 1, `k_byte_num` = 0;
  - then `done` = 1 and `s_ready` = 0.
- 5 bytes 0xAA..0xEE, last on 0xEE: word 0xAABBCCDD with `is_last` = 0, then 0xEE000000 with `is_last` = 1, `byte_num` = 1, then `done`.
- 3 bytes 0x01,0x02,0x03, last: a single word 0x01020300 with `is_last` = 1, `byte_num` = 3; no terminator word.
- `k_buffer_full` held at 1 for 5 cycles with a word pending:
  - `k_in` and `k_in_ready` are stable and `s_ready` = 0;
  - on release, the word transfers and the following bytes pack correctly with no loss or duplication.
- Reset asserted after 2 bytes of a message:
  - next cycle all outputs are at reset values;
  - a new 4-byte message produces exactly its own words.
- In DONE, drive `s_valid` = 1 for 10 cycles: `s_ready` stays 0 and `k_in_ready` stays 0.
